instruction_fetch: RTL and testbench

Fetch stage between the program counter and decode. It issues memory reads at the current program-counter address and drives the counter's step offset so the counter advances only when a read is accepted. Returned instruction words are buffered in a small FIFO and handed to decode over a valid/ready handshake.

---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifetch_fifo.sv | 69 ++++++
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared types for the instruction fetch stage: FSM states, FIFO
//            entry layout and the default sequential step.
// Revision : 1.0
// ============================================================================
package ifetch_pkg;

  localparam int c_instr_bytes_default = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Brief    : Synchronous FIFO of fetched {data, addr} entries with clear.
// Revision : 1.0
// ============================================================================
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic [63:0]             din,
  input  logic                    pop,
  output logic [63:0]             head,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  fetch_entry_t       r_mem [DEPTH];
  logic               w_wr;
  logic               w_rd;

  assign w_rd = pop && (r_count != '0);
  assign w_wr = push && ((r_count != c_cnt_w'(DEPTH)) || w_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign valid = (r_count != '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Single-outstanding fetch stage feeding decode through a FIFO.
//            Optional IFETCH_ALIGN_CHECK_EN adds a sticky fetch_error output.
// Revision : 1.0
// ============================================================================
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int INSTR_BYTES = c_instr_bytes_default
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_address,
  output logic [15:0] pc_offset,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_error
`endif
);

  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t       r_state;
  fetch_state_t       w_next;
  logic [31:0]        r_fetch_addr;
  logic [c_cnt_w-1:0] w_count;
  logic               w_addr_ok;
  logic               w_can_issue;
  logic               w_push;
  logic               w_pop;
  fetch_entry_t       w_entry;
  fetch_entry_t       w_head;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic r_fetch_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_error <= 1'b0;
    end else if (flush) begin
      r_fetch_error <= 1'b0;
    end else if (r_state == IDLE && pc_address[1:0] != 2'b00) begin
      r_fetch_error <= 1'b1;
    end
  end

  assign w_addr_ok   = (pc_address[1:0] == 2'b00) && !r_fetch_error;
  assign fetch_error = r_fetch_error;
`else
  assign w_addr_ok = 1'b1;
`endif

  // Only one read is ever outstanding, so a free slot at issue time is the reservation.
  assign w_can_issue = (w_count < c_cnt_w'(FIFO_DEPTH)) && w_addr_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!flush && w_can_issue) w_next = REQ;
      REQ: begin
        if (flush)        w_next = mem_gnt ? DRAIN : IDLE;
        else if (mem_gnt) w_next = WAIT;
      end
      // A response landing in the flush cycle itself is dropped right here.
      WAIT: begin
        if (mem_rvalid)   w_next = IDLE;
        else if (flush)   w_next = DRAIN;
      end
      DRAIN:   if (mem_rvalid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    pc_offset = 16'd0;
    w_push    = 1'b0;
    case (r_state)
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt && !flush) pc_offset = 16'(INSTR_BYTES);
      end
      WAIT:    w_push = mem_rvalid && !flush;
      default: ;
    endcase
  end

  // One register serves as both the bus address and the entry tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_addr <= 32'd0;
    end else if (r_state == IDLE && w_next == REQ) begin
      r_fetch_addr <= pc_address;
    end
  end

  assign mem_addr     = r_fetch_addr;
  assign w_entry.data = mem_rdata;
  assign w_entry.addr = r_fetch_addr;
  assign w_pop        = instr_valid && instr_ready;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (w_push),
    .din   (w_entry),
    .pop   (w_pop),
    .head  (w_head),
    .valid (instr_valid),
    .count (w_count)
  );

  assign instr_data = w_head.data;
  assign instr_addr = w_head.addr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Scoreboard bench for instruction_fetch with a simple PC model.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch;
  import ifetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_address;
  logic [15:0] pc_offset;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_error;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  fetch_entry_t sb[$];

  instruction_fetch #(
    .FIFO_DEPTH  (2),
    .INSTR_BYTES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_address  (pc_address),
    .pc_offset   (pc_offset),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_error (fetch_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor pops and PC model run around every edge.
  task automatic tick();
    logic [15:0]  off;
    fetch_entry_t e;
    #2;
    off = pc_offset;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("instr_data", {32'd0, instr_data}, {32'd0, e.data});
        check_eq("instr_addr", {32'd0, instr_addr}, {32'd0, e.addr});
      end
    end
    @(posedge clk);
    #1;
    if (reset) pc_address = pc_address + {16'd0, off};
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!mem_req) check_eq("req_timeout", 64'd0, 64'd1);
    else check_eq("mem_addr", {32'd0, mem_addr}, {32'd0, addr});
  endtask

  task automatic serve(input logic [31:0] addr, input logic [31:0] data);
    fetch_entry_t e;
    wait_req(addr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    e.data = data;
    e.addr = addr;
    sb.push_back(e);
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    pc_address  = 32'h0;
    flush       = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_mem_req",    {63'd0, mem_req},     64'd0);
    check_eq("rst_mem_addr",   {32'd0, mem_addr},    64'd0);
    check_eq("rst_pc_offset",  {48'd0, pc_offset},   64'd0);
    check_eq("rst_instr_vld",  {63'd0, instr_valid}, 64'd0);
    check_eq("rst_instr_data", {32'd0, instr_data},  64'd0);
    check_eq("rst_instr_addr", {32'd0, instr_addr},  64'd0);

    reset = 1'b1;
    tick();
    check_eq("first_req",  {63'd0, mem_req},  64'd1);
    check_eq("first_addr", {32'd0, mem_addr}, 64'd0);

    // Best-case transaction, decode stalled.
    mem_gnt = 1'b1;
    #1;
    check_eq("offset_grant", {48'd0, pc_offset}, 64'd4);
    sb.push_back('{data: 32'hDEADBEEF, addr: 32'h0});
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    #1;
    check_eq("offset_after", {48'd0, pc_offset}, 64'd0);
    tick();
    mem_rvalid = 1'b0;
    check_eq("first_valid", {63'd0, instr_valid}, 64'd1);
    check_eq("first_data",  {32'd0, instr_data},  64'hDEADBEEF);
    check_eq("first_iaddr", {32'd0, instr_addr},  64'h0);

    // Fill to depth, then no further requests.
    serve(32'h4, 32'h11111111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("full_no_req", {63'd0, mem_req}, 64'd0);
    end
    check_eq("full_hold_data", {32'd0, instr_data}, 64'hDEADBEEF);
    instr_ready = 1'b1;
    tick();
    tick();
    check_eq("sb_drained_1", 64'(sb.size()), 64'd0);

    // Flush while waiting for data.
    wait_req(32'h8);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    flush      = 1'b1;
    pc_address = 32'h100;
    tick();
    flush = 1'b0;
    check_eq("drain_no_valid", {63'd0, instr_valid}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    check_eq("drain_discard", {63'd0, instr_valid}, 64'd0);
    check_eq("drain_idle",    {63'd0, mem_req},     64'd0);
    serve(32'h100, 32'hA5A5A5A5);

    // Flush coincident with grant.
    wait_req(32'h104);
    mem_gnt    = 1'b1;
    flush      = 1'b1;
    pc_address = 32'h200;
    #1;
    check_eq("flush_gnt_offset", {48'd0, pc_offset}, 64'd0);
    tick();
    mem_gnt    = 1'b0;
    flush      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 1'b0;
    check_eq("flush_gnt_empty", {63'd0, instr_valid}, 64'd0);

    // Stray rvalid outside WAIT/DRAIN.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF0000;
    tick();
    tick();
    mem_rvalid = 1'b0;
    check_eq("stray_rvalid", {63'd0, instr_valid}, 64'd0);
    serve(32'h200, 32'h0C0FFEE0);
    tick();
    tick();
    check_eq("sb_drained_2", 64'(sb.size()), 64'd0);

    // Return to IDLE, then present a misaligned PC.
    flush      = 1'b1;
    pc_address = 32'h6;
    tick();
    flush = 1'b0;
    tick();
`ifdef IFETCH_ALIGN_CHECK_EN
    check_eq("align_err_set", {63'd0, fetch_error}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("align_no_req", {63'd0, mem_req}, 64'd0);
    end
    flush      = 1'b1;
    pc_address = 32'h8;
    tick();
    flush = 1'b0;
    check_eq("align_err_clr", {63'd0, fetch_error}, 64'd0);
    tick();
    check_eq("align_resume_req",  {63'd0, mem_req},  64'd1);
    check_eq("align_resume_addr", {32'd0, mem_addr}, 64'h8);
`else
    check_eq("misalign_req",  {63'd0, mem_req},  64'd1);
    check_eq("misalign_addr", {32'd0, mem_addr}, 64'h6);
`endif

    check_eq("sb_final", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
